// File: rtl/mixed_width_ram.sv
// Byte-lane RAM with power-of-two access sizes, big-endian lane order, alignment exceptions and 1-cycle reads.
// Build option MIXED_WIDTH_RAM_BYPASS_EN: same-cycle write data forwards to overlapping read lanes.
module mixed_width_ram #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  localparam int SIZE_W    = $clog2(LANES) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_en,
  input  logic [SIZE_W-1:0]           w_size,
  input  logic [ADDR_WIDTH-1:0]       w_addr,
  input  logic [DATA_WIDTH*LANES-1:0] w_data,
  input  logic                        r_en,
  input  logic [SIZE_W-1:0]           r_size,
  input  logic [ADDR_WIDTH-1:0]       r_addr,
  output logic [DATA_WIDTH*LANES-1:0] r_data,
  output logic                        r_valid,
  output logic                        wr_exc_flag,
  output logic                        rd_exc_flag,
  output logic [7:0]                  wr_exc_cnt,
  output logic [7:0]                  rd_exc_cnt,
  input  logic                        ctr_clr
);

  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int LOG2_LANES = $clog2(LANES);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Aligned and no wider than LANES; alignment also guarantees no wrap past DEPTH.
  function automatic logic is_legal(input logic [SIZE_W-1:0] size, input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < ADDR_WIDTH; i++)
      mask[i] = (i < int'(size));
    return (int'(size) <= LOG2_LANES) && ((addr & mask) == '0);
  endfunction

  logic                        w_legal, r_legal;
  int                          w_lanes, r_lanes;
  logic [ADDR_WIDTH-1:0]       rd_addr_j;
  logic [DATA_WIDTH*LANES-1:0] rd_next;
`ifdef MIXED_WIDTH_RAM_BYPASS_EN
  int                          w_off;
`endif

  always_comb begin
    w_legal   = is_legal(w_size, w_addr);
    r_legal   = is_legal(r_size, r_addr);
    w_lanes   = 1 << w_size;
    r_lanes   = 1 << r_size;
    rd_next   = '0;
    rd_addr_j = '0;
`ifdef MIXED_WIDTH_RAM_BYPASS_EN
    w_off     = 0;
`endif
    // Result lane j (from LSB) comes from the (n-1-j)th address of the access.
    for (int j = 0; j < LANES; j++) begin
      if (j < r_lanes) begin
        rd_addr_j = r_addr + ADDR_WIDTH'(r_lanes - 1 - j);
        rd_next[j*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr_j];
`ifdef MIXED_WIDTH_RAM_BYPASS_EN
        w_off = int'(rd_addr_j) - int'(w_addr);
        if (w_en && w_legal && w_off >= 0 && w_off < w_lanes)
          rd_next[j*DATA_WIDTH +: DATA_WIDTH] = w_data[(w_lanes - 1 - w_off)*DATA_WIDTH +: DATA_WIDTH];
`endif
      end
    end
  end

  // Memory has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_en && w_legal) begin
      for (int i = 0; i < LANES; i++)
        if (i < w_lanes)
          mem[w_addr + ADDR_WIDTH'(i)] <= w_data[(w_lanes - 1 - i)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      wr_exc_flag <= 1'b0;
      rd_exc_flag <= 1'b0;
      wr_exc_cnt  <= '0;
      rd_exc_cnt  <= '0;
    end else begin
      r_valid     <= r_en;
      if (r_en)
        r_data <= r_legal ? rd_next : '0;
      wr_exc_flag <= w_en && !w_legal;
      rd_exc_flag <= r_en && !r_legal;
      if (ctr_clr)
        wr_exc_cnt <= '0;
      else if (w_en && !w_legal && wr_exc_cnt != 8'hFF)
        wr_exc_cnt <= wr_exc_cnt + 8'd1;
      if (ctr_clr)
        rd_exc_cnt <= '0;
      else if (r_en && !r_legal && rd_exc_cnt != 8'hFF)
        rd_exc_cnt <= rd_exc_cnt + 8'd1;
    end
  end

endmodule
